// File: rtl/mm_verify_ctl.sv
// mm_verify_ctl
// MAC Merge verify/respond controller. It runs the verify handshake with the
// link partner: send a verify mPacket, then wait a bounded number of timebase
// ticks for a respond mPacket. It retries up to VERIFY_LIMIT times before it
// declares failure. Independently of that handshake, it answers every
// received verify mPacket with a respond mPacket.
//
// Optional feature macro: MM_VERIFY_AUTORETRY_EN
//   When defined, VERIFY_FAIL waits RETRY_TICKS ticks and then restarts the
//   whole sequence from INIT_VERIFICATION. When undefined, VERIFY_FAIL is
//   terminal until a force condition occurs.
//
// Ports
//   clk, reset_n        clock and asynchronous active-low reset
//   reset_begin         MAC Merge reset request (level, forces init)
//   link_fail           link down (level, forces init)
//   disable_verify      management disable of verification (level, forces init)
//   p_enable            preemption enabled (low forces init)
//   tick                one-cycle timebase strobe
//   verify_time         verify timeout in ticks, sampled on timer load
//   send_v / send_v_ack verify mPacket request / transmitted pulse
//   send_r / send_r_ack respond mPacket request / transmitted pulse
//   rcv_v, rcv_r        received verify / respond mPacket pulses
//   verified            verification succeeded
//   verify_fail         verification failed
//   verify_cnt          verify mPackets sent, saturating at VERIFY_LIMIT
//   state               current verify state, for debug
module mm_verify_ctl #(
  parameter int VERIFY_LIMIT = 3,
  parameter int TIMER_W      = 8,
  parameter int RETRY_TICKS  = 100,
  localparam int CW          = $clog2(VERIFY_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               reset_begin,
  input  logic               link_fail,
  input  logic               disable_verify,
  input  logic               p_enable,
  input  logic               tick,
  input  logic [TIMER_W-1:0] verify_time,
  output logic               send_v,
  input  logic               send_v_ack,
  output logic               send_r,
  input  logic               send_r_ack,
  input  logic               rcv_v,
  input  logic               rcv_r,
  output logic               verified,
  output logic               verify_fail,
  output logic [CW-1:0]      verify_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    INIT_VERIFICATION = 3'b000,
    VERIFICATION_IDLE = 3'b001,
    SEND_VERIFY       = 3'b010,
    WAIT_FOR_RESPONSE = 3'b011,
    VERIFIED          = 3'b100,
    VERIFY_FAIL       = 3'b101
  } state_t;

  localparam logic [CW-1:0] LIMIT_C = CW'(VERIFY_LIMIT);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               force_init;
  logic               respond_clr;
  logic               expired;

  // Force conditions: anything here sends the verify machine back to init.
  // disable_verify is left out of the respond clear so the peer is still answered.
  assign force_init  = reset_begin | link_fail | disable_verify | ~p_enable;
  assign respond_clr = reset_begin | link_fail | ~p_enable;

  // The timer expires on the tick that takes it from 1 to 0. The zero check
  // only covers a timer that was loaded with zero (RETRY_TICKS = 0).
  assign expired = (timer_q == '0) || (tick && (timer_q == TIMER_W'(1)));

  // Next-state logic for the verify sequence, including the timer and the attempt counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    if (force_init) begin
      state_d = INIT_VERIFICATION;
    end else begin
      case (state_q)
        INIT_VERIFICATION: state_d = VERIFICATION_IDLE;
        VERIFICATION_IDLE: state_d = SEND_VERIFY;
        SEND_VERIFY: begin
          if (send_v_ack) begin
            state_d = WAIT_FOR_RESPONSE;
            cnt_d   = (cnt_q < LIMIT_C) ? cnt_q + CW'(1) : cnt_q;
            timer_d = (verify_time == '0) ? TIMER_W'(1) : verify_time;
          end
        end
        WAIT_FOR_RESPONSE: begin
          if (rcv_r) begin
            state_d = VERIFIED;
          end else if (expired) begin
            if (cnt_q < LIMIT_C) begin
              state_d = VERIFICATION_IDLE;
            end else begin
              state_d = VERIFY_FAIL;
`ifdef MM_VERIFY_AUTORETRY_EN
              timer_d = TIMER_W'(RETRY_TICKS);
`endif
            end
          end else if (tick) begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        VERIFIED: state_d = VERIFIED;
        VERIFY_FAIL: begin
`ifdef MM_VERIFY_AUTORETRY_EN
          if (expired) begin
            state_d = INIT_VERIFICATION;
          end else if (tick) begin
            timer_d = timer_q - TIMER_W'(1);
          end
`else
          state_d = VERIFY_FAIL;
`endif
        end
        default: state_d = INIT_VERIFICATION;
      endcase
    end
    // Clear the counter and the timer together with the state. Then the debug
    // state and verify_cnt read back as a consistent pair.
    if (state_d == INIT_VERIFICATION) begin
      cnt_d   = '0;
      timer_d = '0;
    end
  end

  // Verify state register. The status outputs are registered from the next
  // state, so each output lines up with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT_VERIFICATION;
      timer_q     <= '0;
      cnt_q       <= '0;
      send_v      <= 1'b0;
      verified    <= 1'b0;
      verify_fail <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      send_v      <= (state_d == SEND_VERIFY);
      verified    <= (state_d == VERIFIED);
      verify_fail <= (state_d == VERIFY_FAIL);
    end
  end

  // Respond request. A new rcv_v beats a simultaneous ack, so a verify that
  // arrives while a respond is leaving still gets its own answer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      send_r <= 1'b0;
    end else if (respond_clr) begin
      send_r <= 1'b0;
    end else if (rcv_v) begin
      send_r <= 1'b1;
    end else if (send_r_ack) begin
      send_r <= 1'b0;
    end
  end

  assign verify_cnt = cnt_q;
  assign state      = state_q;

endmodule

// File: doc/mm_verify_ctl.md
# mm_verify_ctl

Clocked, parametrised IEEE 802.3br MAC Merge verify/respond controller. Runs the Figure 99-8 verify sequence with an integrated verify timer and a configurable retry limit. It also runs the respond process that answers received verify mPackets. It sits between the MAC Merge management inputs and the express/preemptable transmit and receive processes, and replaces the event-driven verify model.

## Interface

Parameters:
- VERIFY_LIMIT, 3: number of verify mPackets sent before declaring failure (1..15).
- TIMER_W, 8: width of the verify timer and of verify_time.
- RETRY_TICKS, 100: hold-off in ticks before auto-retry; used only with MM_VERIFY_AUTORETRY_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reset_begin  in  1  synchronous MAC Merge reset request, level.
- link_fail  in  1  link down, level.
- disable_verify  in  1  management disable of verification, level.
- p_enable  in  1  preemption enabled, level.
- tick  in  1  timebase strobe (nominally 1 ms), one cycle wide.
- verify_time  in  TIMER_W  verify timeout in ticks, sampled on timer load.
- send_v  out  1  request to transmit a verify mPacket.
- send_v_ack  in  1  pulse: the verify mPacket has been transmitted.
- send_r  out  1  request to transmit a respond mPacket.
- send_r_ack  in  1  pulse: the respond mPacket has been transmitted.
- rcv_v  in  1  pulse: a verify mPacket was received.
- rcv_r  in  1  pulse: a respond mPacket was received.
- verified  out  1  verification succeeded.
- verify_fail  out  1  verification failed.
- verify_cnt  out  CW  verify mPackets sent; CW = $clog2(VERIFY_LIMIT+1).
- state  out  3  current verify state, for debug.

## Operation

- force = reset_begin | link_fail | disable_verify | !p_enable. When force is high, next state is INIT_VERIFICATION.
- States and encodings: INIT_VERIFICATION 000, VERIFICATION_IDLE 001, SEND_VERIFY 010, WAIT_FOR_RESPONSE 011, VERIFIED 100, VERIFY_FAIL 101. Unused codes go to INIT_VERIFICATION.
- INIT_VERIFICATION:
  - Clears verified, verify_fail, verify_cnt, send_v and the timer.
  - Goes to VERIFICATION_IDLE on the first cycle where force is low.
- VERIFICATION_IDLE: goes to SEND_VERIFY on the next cycle.
- SEND_VERIFY:
  - send_v is high.
  - On send_v_ack: clear send_v, increment verify_cnt, load the timer with max(verify_time, 1), go to WAIT_FOR_RESPONSE.
- WAIT_FOR_RESPONSE:
  - The timer decrements on each tick; timer_done means the timer has reached 0.
  - rcv_r goes to VERIFIED. rcv_r has priority over timer_done in the same cycle.
  - timer_done with verify_cnt < VERIFY_LIMIT goes to VERIFICATION_IDLE.
  - timer_done with verify_cnt ≥ VERIFY_LIMIT goes to VERIFY_FAIL.
- VERIFIED: verified = 1. The state is held until force goes high.
- VERIFY_FAIL: verify_fail = 1. The state is held until force goes high; see Configuration for auto-retry.
- verify_cnt saturates at VERIFY_LIMIT and never wraps.
- Respond process (independent of the verify state machine):
  - rcv_v sets send_r; send_r_ack clears it.
  - If rcv_v and send_r_ack arrive in the same cycle, send_r stays 1.
  - A repeated rcv_v while send_r is already high is coalesced.
  - send_r is cleared by reset_begin | link_fail | !p_enable.
  - disable_verify does not clear send_r: the block still answers the peer.
- send_v_ack outside SEND_VERIFY is ignored. send_r_ack while send_r is low is ignored.

## Timing

- Reset values (reset_n low): state = 000; send_v, send_r, verified and verify_fail are 0; verify_cnt = 0; timer = 0.
- All outputs are registered. A state change is visible one cycle after the qualifying input edge.
- Minimum path from force deasserting to send_v high: 2 cycles (INIT_VERIFICATION → VERIFICATION_IDLE → SEND_VERIFY).
- The timer load and the verify_cnt increment happen in the same cycle as the state becomes WAIT_FOR_RESPONSE.
- Timeout occurs verify_time ticks after the load. A tick in the load cycle is not counted.
- rcv_v to send_r high: 1 cycle.
- If force asserts mid-operation, the next cycle is INIT_VERIFICATION and any pending send_v is dropped. send_r is dropped only under the respond-process clear conditions above.

## Configuration

- MM_VERIFY_AUTORETRY_EN defined:
  - In VERIFY_FAIL, the timer is loaded with RETRY_TICKS.
  - On expiry the state goes to INIT_VERIFICATION, clearing verify_fail and verify_cnt, and the full verify sequence restarts.
- MM_VERIFY_AUTORETRY_EN undefined:
  - VERIFY_FAIL is terminal until force goes high.
  - RETRY_TICKS is unused.

## Test plan

- Reset and release with p_enable=1 and all other force inputs 0 → send_v is high on cycle 2. Pulse send_v_ack → verify_cnt=1 and state=011.
- verify_time=4, rcv_r pulsed after 2 ticks → verified=1, state=100, verify_cnt=1, send_v stays 0.
- VERIFY_LIMIT=3, no rcv_r → three send_v cycles, then verify_fail=1, state=101, verify_cnt=3. With MM_VERIFY_AUTORETRY_EN and RETRY_TICKS=5: state=000 after 5 ticks, then send_v reasserts.
- rcv_r and the timeout tick in the same cycle with verify_cnt=3 → VERIFIED, not VERIFY_FAIL.
- link_fail pulsed while in WAIT_FOR_RESPONSE with send_r=1 → state=000, verify_cnt=0, send_r=0. disable_verify pulsed instead → send_r stays 1.
- rcv_v and send_r_ack in the same cycle with send_r=1 → send_r stays 1. A following send_r_ack → send_r=0.
